ram_read_responder: RTL
=======================

Name: ram_read_responder

Overview:
- Byte-addressed program/data memory that serves the instruction reader's fetch and operand-read requests over the readReq/ramAddress/ramIn/readAck handshake.
- Sits directly downstream of the reader; a loader write port lets the bench or boot logic preload the image.
- Read latency is configurable so the reader can be exercised against slow memory.

Parameters:
- RAMSIZE, 64, memory size in bytes; must be a power of two, at most 2**WIDTH.
- WIDTH, 8, address width in bits.
- LATENCY, 2, extra wait cycles before the acknowledge; legal range 0..15.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- readReq  input  1  read request from reader; level, held until readAck is seen
- ramAddress  input  WIDTH  byte address of the 32-bit word to read
- ramIn  output  32  read data to reader, little-endian
- readAck  output  1  one-cycle pulse; ramIn is valid in the same cycle
- wr_en  input  1  loader byte write strobe
- wr_addr  input  WIDTH  loader byte address
- wr_data  input  8  loader byte data
- busy  output  1  high in WAIT or ACK state
- protocol_err  output  1  sticky flag: readReq dropped before acknowledge
- read_count  output  16  number of completed reads; wraps at 2**16

Behaviour:
- Reset, asynchronous:
  - readAck=0, ramIn=0, busy=0, protocol_err=0, read_count=0, state=IDLE.
  - Memory array is NOT cleared; reset mid-read abandons the read with no ack.
- State IDLE:
  - On an edge with readReq=1: capture ramAddress into addr_q, load cnt=LATENCY, go to WAIT.
- State WAIT:
  - If readReq=0 at an edge: set protocol_err, go to IDLE, no ack.
  - Else if cnt!=0: decrement cnt.
  - Else (cnt==0): drive ramIn and readAck=1, increment read_count, go to ACK.
- ramIn assembly:
  - ramIn[7:0]=mem[a], [15:8]=mem[a+1], [23:16]=mem[a+2], [31:24]=mem[a+3].
  - Each byte index is taken mod RAMSIZE (wrap-around at the top of memory).
  - Addresses need not be word-aligned.
- State ACK (one cycle):
  - readAck returns to 0; ramIn holds its value until the next ack.
  - Go to DONE.
- State DONE:
  - Wait for readReq=0 at an edge, then go to IDLE.
  - A new request therefore needs readReq low for at least one sampled edge.
  - The reader drops readReq in the cycle after it sees the ack, so DONE normally lasts exactly one cycle.
- Latency: the request is sampled at edge E0; readAck is high in the cycle following edge E0+LATENCY+1.
  - LATENCY=0 gives ack one cycle after the request edge.
- Back-to-back requests: the reader's req-low gap of one cycle must be honoured.
  - No ack may be issued for a request that has not been freshly sampled in IDLE.
- Loader port:
  - With wr_en=1 at an edge, mem[wr_addr mod RAMSIZE] <= wr_data.
  - Writes are accepted in every state.
  - Read data is sampled from the array at the ack edge: a write on that same edge is NOT visible, a write on any earlier edge is.
- ramAddress changes while in WAIT are ignored; addr_q is used.

Decomposition:
- Shared package: state encoding (IDLE, WAIT, ACK, DONE), LATENCY_MAX=15, counter width constant.
- One natural sub-module: byte_ram (RAMSIZE x 8 array, one write port, four combinational read taps with modulo wrap).
- Handshake FSM and counters stay in ram_read_responder.

Test Plan:
- Preload bytes 0..3 = 01,05,10,00; readReq high at address 0 with LATENCY=2 -> readAck pulses exactly one cycle, 3 edges after the request edge; ramIn=32'h00100501; read_count=1.
- Drive the full reader sequence (fetch at 0, req low one cycle, operand read at 0x10 holding 0x3F800000) -> two acks, second ramIn=32'h3F800000, protocol_err=0.
- Read at address 62 with RAMSIZE=64, bytes 62,63,0,1 = AA,BB,CC,DD -> ramIn=32'hDDCCBBAA.
- Loader writes address 4 := 77 on the ack edge of a read of address 4 -> ramIn byte0 is the old value; an immediate re-read returns 77.
- Drop readReq during WAIT (LATENCY=5) -> no readAck, protocol_err=1 and stays 1, state returns to IDLE; the next request completes normally.
- Assert reset during WAIT -> readAck=0, busy=0, read_count=0; memory contents preserved (a re-read returns the preloaded data).

Source files
------------

// File: rtl/ram_read_responder_pkg.sv
// Shared types and constants for the RAM read responder: FSM encoding,
// latency counter sizing and read counter width.
package ram_read_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int LATENCY_MAX  = 15;
    localparam int CNT_W        = $clog2(LATENCY_MAX + 1);
    localparam int READ_COUNT_W = 16;

endpackage

// File: rtl/ram_read_responder_byte_ram.sv
// Byte-wide memory with one loader write port and four combinational read
// taps that assemble a little-endian 32-bit word, wrapping at the top.
module byte_ram #(
    parameter int RAMSIZE = 64,
    parameter int WIDTH   = 8
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_addr,
    input  logic [7:0]       wr_data,
    input  logic [WIDTH-1:0] rd_addr,
    output logic [31:0]      rd_data
);

    localparam int AW = (RAMSIZE > 1) ? $clog2(RAMSIZE) : 1;

    logic [7:0] mem_q [RAMSIZE];

    // RAMSIZE is a power of two, so truncating the address is the modulo.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[AW'(wr_addr)] <= wr_data;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < 4; k++) begin
            rd_data[8*k +: 8] = mem_q[AW'(rd_addr + WIDTH'(k))];
        end
    end

endmodule

// File: rtl/ram_read_responder.sv
// Memory responder for the instruction reader: level readReq / pulse readAck
// handshake with configurable wait cycles, plus a byte loader port.
module ram_read_responder
    import ram_read_responder_pkg::*;
#(
    parameter int RAMSIZE = 64,
    parameter int WIDTH   = 8,
    parameter int LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    readReq,
    input  logic [WIDTH-1:0]        ramAddress,
    output logic [31:0]             ramIn,
    output logic                    readAck,
    input  logic                    wr_en,
    input  logic [WIDTH-1:0]        wr_addr,
    input  logic [7:0]              wr_data,
    output logic                    busy,
    output logic                    protocol_err,
    output logic [READ_COUNT_W-1:0] read_count,
    output logic [1:0]              dbg_state
);

    // Handshake: readReq is a level held by the reader until it sees the
    // one-cycle readAck pulse; ramIn is valid with readAck and holds after.
    // A new request is only taken in IDLE, after readReq was seen low in DONE.

    state_t                  state_q, state_d;
    logic [WIDTH-1:0]        addr_q, addr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [31:0]             ram_in_q, ram_in_d;
    logic                    read_ack_q, read_ack_d;
    logic                    err_q, err_d;
    logic [READ_COUNT_W-1:0] count_q, count_d;
    logic [31:0]             rd_word;

    byte_ram #(
        .RAMSIZE(RAMSIZE),
        .WIDTH  (WIDTH)
    ) u_byte_ram (
        .clk    (clk),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .rd_addr(addr_q),
        .rd_data(rd_word)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            ram_in_q   <= '0;
            read_ack_q <= 1'b0;
            err_q      <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            ram_in_q   <= ram_in_d;
            read_ack_q <= read_ack_d;
            err_q      <= err_d;
            count_q    <= count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        ram_in_d   = ram_in_q;
        read_ack_d = 1'b0;
        err_d      = err_q;
        count_d    = count_q;
        case (state_q)
            ST_IDLE: begin
                if (readReq) begin
                    addr_d  = ramAddress;
                    cnt_d   = CNT_W'(LATENCY);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!readReq) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    // Sampled on this edge, so a same-edge loader write is not seen.
                    ram_in_d   = rd_word;
                    read_ack_d = 1'b1;
                    count_d    = count_q + 1'b1;
                    state_d    = ST_ACK;
                end
            end
            ST_ACK: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (!readReq) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign ramIn        = ram_in_q;
    assign readAck      = read_ack_q;
    assign busy         = (state_q == ST_WAIT) || (state_q == ST_ACK);
    assign protocol_err = err_q;
    assign read_count   = count_q;
    assign dbg_state    = state_q;

endmodule
